// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator.
// One shared frame counter drives N_CH registered PWM outputs. Host writes
// set per-channel target widths; the widths actually driven only change at
// frame boundaries, optionally rate-limited by SLEW_CYC per frame.
module servo_pwm_multi #(
    parameter int N_CH       = 4,
    parameter int PERIOD_CYC = 1_000_000,
    parameter int MIN_CYC    = 50_000,
    parameter int MAX_CYC    = 100_000,
    parameter int POS_W      = 8,
    parameter int RES_CYC    = 200,
    parameter int SLEW_CYC   = 0,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [POS_W-1:0] wr_pos,
    input  logic [N_CH-1:0] en_i,
    output logic [N_CH-1:0] pwm_o,
    output logic            frame_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(PERIOD_CYC);
    localparam int W_W   = $clog2(MAX_CYC + 1);
    localparam logic [W_W-1:0] NEUTRAL_W = W_W'((MIN_CYC + MAX_CYC) / 2);
    localparam logic [W_W-1:0] MAX_W     = W_W'(MAX_CYC);

    // Refuse to build with an impossible timing relationship.
    generate
        if (!(MIN_CYC < MAX_CYC && MAX_CYC < PERIOD_CYC && N_CH >= 1)) begin : g_bad_params
            $error("servo_pwm_multi: need MIN_CYC < MAX_CYC < PERIOD_CYC and N_CH >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             frame_end;
    logic [W_W-1:0]   tgt_w  [N_CH];
    logic [W_W-1:0]   cur_w  [N_CH];
    logic [W_W-1:0]   next_w [N_CH];
    logic [N_CH-1:0]  en_lat;
    logic [63:0]      raw;
    logic [W_W-1:0]   wr_w;
    logic             wr_valid;
    logic             any_diff;

    assign frame_end = (cnt == CNT_W'(PERIOD_CYC - 1));

    // Position-to-width conversion, wide enough that the clamp sees the true value.
    always_comb begin
        raw      = 64'(MIN_CYC) + 64'(wr_pos) * 64'(RES_CYC);
        wr_w     = (raw > 64'(MAX_CYC)) ? MAX_W : raw[W_W-1:0];
        wr_valid = (32'(wr_ch) < N_CH);
    end

    // Free-running frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         cnt <= '0;
        else if (frame_end) cnt <= '0;
        else                cnt <= cnt + 1'b1;
    end

    // frame_o is registered, so it is armed one cycle ahead of the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_o <= 1'b0;
        else        frame_o <= (cnt == CNT_W'(PERIOD_CYC - 2));
    end

    // Host writes land in the target registers immediately; last write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) tgt_w[i] <= NEUTRAL_W;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (wr_en && wr_valid && wr_ch == CH_W'(i)) tgt_w[i] <= wr_w;
        end
    end

    // Width each channel will adopt at the next boundary, slew-limited if enabled.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            next_w[i] = tgt_w[i];
            if (SLEW_CYC != 0) begin
                if (tgt_w[i] > cur_w[i]) begin
                    if (32'(tgt_w[i] - cur_w[i]) > SLEW_CYC) next_w[i] = cur_w[i] + W_W'(SLEW_CYC);
                end else begin
                    if (32'(cur_w[i] - tgt_w[i]) > SLEW_CYC) next_w[i] = cur_w[i] - W_W'(SLEW_CYC);
                end
            end
        end
    end

    // Widths and enables only change on the last cycle of a frame, keeping pulses glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_lat <= '0;
            for (int i = 0; i < N_CH; i++) cur_w[i] <= NEUTRAL_W;
        end else if (frame_end) begin
            en_lat <= en_i;
            for (int i = 0; i < N_CH; i++) cur_w[i] <= next_w[i];
        end
    end

    // Registered pulse compare; high for cnt in 0..cur_w-1, seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_o <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                pwm_o[i] <= en_lat[i] && (32'(cnt) < 32'(cur_w[i]));
        end
    end

    // Any channel still converging toward its target.
    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (cur_w[i] != tgt_w[i]) any_diff = 1'b1;
    end

    // Registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_o <= 1'b0;
        else        busy_o <= any_diff;
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed testbench for servo_pwm_multi: a 4-channel unlimited-slew instance
// and a 6-channel instance with SLEW_CYC=10, both on a 1000-cycle frame.
module tb_servo_pwm_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_en_s = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [2:0] wr_ch_s = '0;
    logic [7:0] wr_pos = '0;
    logic [3:0] en_i = 4'hF;
    logic [5:0] en_s = 6'h3F;
    logic [3:0] pwm_o;
    logic       frame_o, busy_o;
    logic [5:0] pwm_s;
    logic       frame_s, busy_s;

    int errors = 0;
    int checks = 0;
    int w[4];
    int ws[6];
    int flen;
    logic busy_end, busy_s_end, frame_s_end;

    servo_pwm_multi #(.N_CH(4), .PERIOD_CYC(1000), .MIN_CYC(50), .MAX_CYC(100),
                      .POS_W(8), .RES_CYC(1), .SLEW_CYC(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .en_i(en_i), .pwm_o(pwm_o), .frame_o(frame_o), .busy_o(busy_o));

    servo_pwm_multi #(.N_CH(6), .PERIOD_CYC(1000), .MIN_CYC(50), .MAX_CYC(100),
                      .POS_W(8), .RES_CYC(1), .SLEW_CYC(10)) dut_s (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .wr_ch(wr_ch_s), .wr_pos(wr_pos),
        .en_i(en_s), .pwm_o(pwm_s), .frame_o(frame_s), .busy_o(busy_s));

    always #5 clk = ~clk;

    // Counts high cycles per channel until the main frame_o pulse is seen.
    task automatic measure_frame();
        int n;
        n = 0;
        flen = -1;
        for (int i = 0; i < 4; i++) w[i] = 0;
        for (int i = 0; i < 6; i++) ws[i] = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) if (pwm_o[i] === 1'b1) w[i]++;
            for (int i = 0; i < 6; i++) if (pwm_s[i] === 1'b1) ws[i]++;
            if (frame_o === 1'b1) begin
                flen = n;
                busy_end = busy_o;
                busy_s_end = busy_s;
                frame_s_end = frame_s;
                break;
            end
        end
    endtask

    task automatic write_main(input logic [1:0] ch, input logic [7:0] pos);
        @(negedge clk);
        wr_ch = ch; wr_pos = pos; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_slew(input logic [2:0] ch, input logic [7:0] pos);
        @(negedge clk);
        wr_ch_s = ch; wr_pos = pos; wr_en_s = 1'b1;
        @(negedge clk);
        wr_en_s = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pwm_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_pwm: got %h expected 0", pwm_o); end
        checks++; if (frame_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame: got %b expected 0", frame_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (pwm_s !== 6'h0) begin errors++; $display("[TB] FAIL reset_pwm_s: got %h expected 0", pwm_s); end
        rst_n = 1'b1;
        measure_frame();
        checks++; if (flen !== 999) begin errors++; $display("[TB] FAIL first_frame_len: got %0d expected 999", flen); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== 0) begin errors++; $display("[TB] FAIL first_frame_off ch%0d: got %0d expected 0", i, w[i]); end
        end
        measure_frame();
        checks++; if (flen !== 1000) begin errors++; $display("[TB] FAIL frame_len: got %0d expected 1000", flen); end
        checks++; if (frame_s_end !== 1'b1) begin errors++; $display("[TB] FAIL frame_s_sync: got %b expected 1", frame_s_end); end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL neutral_busy: got %b expected 0", busy_end); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== 75) begin errors++; $display("[TB] FAIL neutral_width ch%0d: got %0d expected 75", i, w[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (ws[i] !== 75) begin errors++; $display("[TB] FAIL neutral_width_s ch%0d: got %0d expected 75", i, ws[i]); end
        end
    endtask

    task automatic test_write_clamp();
        int exp_w[4] = '{50, 75, 100, 100};
        fork
            measure_frame();
            begin
                repeat (100) @(negedge clk);
                write_main(2'd0, 8'd0);
                write_main(2'd1, 8'd25);
                write_main(2'd2, 8'd255);
                write_main(2'd3, 8'd50);
            end
        join
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== 75) begin errors++; $display("[TB] FAIL clamp_same_frame ch%0d: got %0d expected 75", i, w[i]); end
        end
        checks++; if (busy_end !== 1'b1) begin errors++; $display("[TB] FAIL clamp_busy_pending: got %b expected 1", busy_end); end
        measure_frame();
        checks++; if (flen !== 1000) begin errors++; $display("[TB] FAIL clamp_frame_len: got %0d expected 1000", flen); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== exp_w[i]) begin errors++; $display("[TB] FAIL clamp_width ch%0d: got %0d expected %0d", i, w[i], exp_w[i]); end
        end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL clamp_busy_done: got %b expected 0", busy_end); end
    endtask

    task automatic test_last_write_wins();
        int exp_w[4] = '{90, 75, 100, 100};
        fork
            measure_frame();
            begin
                repeat (200) @(negedge clk);
                write_main(2'd0, 8'd10);
                write_main(2'd0, 8'd40);
            end
        join
        checks++; if (w[0] !== 50) begin errors++; $display("[TB] FAIL lww_same_frame ch0: got %0d expected 50", w[0]); end
        measure_frame();
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== exp_w[i]) begin errors++; $display("[TB] FAIL lww_width ch%0d: got %0d expected %0d", i, w[i], exp_w[i]); end
        end
    endtask

    task automatic test_boundary_write();
        int exp_a[4] = '{90, 75, 100, 100};
        int exp_b[4] = '{90, 50, 100, 100};
        wr_ch = 2'd1; wr_pos = 8'd0; wr_en = 1'b1;
        fork
            measure_frame();
            begin
                @(negedge clk);
                wr_en = 1'b0;
            end
        join
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== exp_a[i]) begin errors++; $display("[TB] FAIL boundary_hold ch%0d: got %0d expected %0d", i, w[i], exp_a[i]); end
        end
        checks++; if (busy_end !== 1'b1) begin errors++; $display("[TB] FAIL boundary_busy: got %b expected 1", busy_end); end
        measure_frame();
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL boundary_apply ch%0d: got %0d expected %0d", i, w[i], exp_b[i]); end
        end
    endtask

    task automatic test_slew();
        int exp2[3] = '{85, 95, 100};
        int exp3[3] = '{65, 55, 52};
        logic exp_busy[3] = '{1'b1, 1'b1, 1'b0};
        fork
            measure_frame();
            begin
                repeat (50) @(negedge clk);
                write_slew(3'd2, 8'd50);
                write_slew(3'd3, 8'd2);
                write_slew(3'd6, 8'd0);
                write_slew(3'd7, 8'd0);
            end
        join
        for (int i = 0; i < 6; i++) begin
            checks++; if (ws[i] !== 75) begin errors++; $display("[TB] FAIL slew_same_frame ch%0d: got %0d expected 75", i, ws[i]); end
        end
        checks++; if (busy_s_end !== 1'b1) begin errors++; $display("[TB] FAIL slew_busy_pending: got %b expected 1", busy_s_end); end
        for (int f = 0; f < 3; f++) begin
            measure_frame();
            checks++; if (ws[2] !== exp2[f]) begin errors++; $display("[TB] FAIL slew_up f%0d: got %0d expected %0d", f, ws[2], exp2[f]); end
            checks++; if (ws[3] !== exp3[f]) begin errors++; $display("[TB] FAIL slew_down f%0d: got %0d expected %0d", f, ws[3], exp3[f]); end
            checks++; if (busy_s_end !== exp_busy[f]) begin errors++; $display("[TB] FAIL slew_busy f%0d: got %b expected %b", f, busy_s_end, exp_busy[f]); end
            for (int i = 0; i < 6; i++) begin
                if (i != 2 && i != 3) begin
                    checks++; if (ws[i] !== 75) begin errors++; $display("[TB] FAIL slew_other f%0d ch%0d: got %0d expected 75", f, i, ws[i]); end
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        repeat (41) @(negedge clk);
        checks++; if (pwm_o !== 4'hF) begin errors++; $display("[TB] FAIL pre_reset_pulses: got %h expected f", pwm_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (pwm_o !== 4'h0) begin errors++; $display("[TB] FAIL async_reset_pwm: got %h expected 0", pwm_o); end
        checks++; if (pwm_s !== 6'h0) begin errors++; $display("[TB] FAIL async_reset_pwm_s: got %h expected 0", pwm_s); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure_frame();
        checks++; if (flen !== 999) begin errors++; $display("[TB] FAIL restart_len: got %0d expected 999", flen); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== 0) begin errors++; $display("[TB] FAIL restart_off ch%0d: got %0d expected 0", i, w[i]); end
        end
        measure_frame();
        for (int i = 0; i < 4; i++) begin
            checks++; if (w[i] !== 75) begin errors++; $display("[TB] FAIL restart_width ch%0d: got %0d expected 75", i, w[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (ws[i] !== 75) begin errors++; $display("[TB] FAIL restart_width_s ch%0d: got %0d expected 75", i, ws[i]); end
        end
        checks++; if (busy_end !== 1'b0) begin errors++; $display("[TB] FAIL restart_busy: got %b expected 0", busy_end); end
    endtask

    // Safety net so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_write_clamp();
        test_last_write_wins();
        test_boundary_write();
        test_slew();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
